// File: rtl/sc_s2d_counter.sv
// sc_s2d_counter: stochastic-to-digital converter.
// Counts the 1s in a unipolar bitstream over a window of 2^PRECISION accepted
// samples and returns a saturated PRECISION-bit result through a valid/ready
// handshake. A new window starts on `start` while idle.
// Optional build macro SC_S2D_BIPOLAR_EN: when defined, the result is the
// two's-complement bipolar value clamp(ones - 2^(PRECISION-1)); when undefined,
// the result is the unipolar value min(ones, 2^PRECISION - 1).
module sc_s2d_counter #(
  parameter int PRECISION = 8
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Sample index of the last sample in a window (2^PRECISION - 1, zero-based).
  localparam logic [PRECISION:0] LAST_SAMPLE = {1'b0, {PRECISION{1'b1}}};
  localparam logic [PRECISION:0] CNT_ONE     = {{PRECISION{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [PRECISION:0]   samp_q, samp_d;
  logic [PRECISION:0]   ones_q, ones_d;
  logic [PRECISION-1:0] out_q, out_d;
  logic [PRECISION:0]   ones_inc;

  // Map a full-window ones count (0 .. 2^PRECISION) to the result encoding.
  function automatic logic [PRECISION-1:0] to_result(input logic [PRECISION:0] ones);
`ifdef SC_S2D_BIPOLAR_EN
    // ones - 2^(PRECISION-1) is just the low bits with the MSB inverted; the
    // only out-of-range value is ones = 2^PRECISION, which clamps to max positive.
    if (ones[PRECISION]) to_result = {1'b0, {(PRECISION-1){1'b1}}};
    else                 to_result = {~ones[PRECISION-1], ones[PRECISION-2:0]};
`else
    // A full all-ones window saturates instead of wrapping to zero.
    if (ones[PRECISION]) to_result = {PRECISION{1'b1}};
    else                 to_result = ones[PRECISION-1:0];
`endif
  endfunction

  // Next-state, counter and result-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = state_q;
    samp_d   = samp_q;
    ones_d   = ones_q;
    out_d    = out_q;
    ones_inc = ones_q + (in ? CNT_ONE : '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          samp_d  = '0;
          ones_d  = '0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          samp_d = samp_q + CNT_ONE;
          ones_d = ones_inc;
          if (samp_q == LAST_SAMPLE) begin
            state_d = S_DONE;
            out_d   = to_result(ones_inc);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and result register; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      samp_q  <= '0;
      ones_q  <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      samp_q  <= samp_d;
      ones_q  <= ones_d;
      out_q   <= out_d;
    end
  end

  // Outputs decode straight from registered state; nothing from `in` reaches them.
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_sc_s2d_counter.sv
// Self-checking bench for sc_s2d_counter at PRECISION=4 (16-sample window).
// Expected results come from a small reference model and flow through a
// scoreboard queue: pushed when a window is driven, popped when out_valid rises.
module tb_sc_s2d_counter;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out;

  int checks = 0;
  int errors = 0;

  logic [P-1:0] exp_q[$];
  logic [P-1:0] last_out;

  sc_s2d_counter #(.PRECISION(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in        (in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Reference model: result for a window containing `ones` 1s.
  function automatic logic [P-1:0] model(input int ones);
    int v;
`ifdef SC_S2D_BIPOLAR_EN
    v = ones - 8;
    if (v > 7)  v = 7;
    if (v < -8) v = -8;
`else
    v = (ones > 15) ? 15 : ones;
`endif
    return P'(v);
  endfunction

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in = 1'b0; out_ready = 1'b0;
    last_out = '0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b out_valid=%b out=%0d, want 0/0/0", busy, out_valid, out);
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b, want 0", busy);
    end
  endtask

  // Drive one full window; optional in_valid=0 gap before every sample (with
  // the inverted bit on `in`), optional start pulses throughout ACCUM.
  task automatic run_window(input logic [15:0] pat, input bit gaps, input bit pulses);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enter_accum: busy=%b out_valid=%b, want 1/0", busy, out_valid);
    end
    checks++;
    if (out !== last_out) begin
      errors++;
      $display("FAIL out_held_in_accum: out=%0d, want %0d", out, last_out);
    end
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in = ~pat[i]; start = pulses;
        step();
      end
      in_valid = 1'b1; in = pat[i]; start = pulses;
      step();
      if (i < 15) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL early_valid: sample %0d out_valid=%b busy=%b, want 0/1", i, out_valid, busy);
        end
      end
    end
    in_valid = 1'b0; in = 1'b0; start = 1'b0;
    exp_q.push_back(model($countones(pat)));
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%b one edge after last sample, want 1", out_valid);
    end
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, hold
  // out_ready low for `hold` cycles, then complete the handshake.
  task automatic get_result(input int hold, input bit start_on_hs);
    logic [P-1:0] exp;
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, want 1", out_valid, n);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got out=%0d, want a queued result", out);
      exp = out;
    end else begin
      exp = exp_q.pop_front();
      if (out !== exp) begin
        errors++;
        $display("FAIL result: out=%0d, want %0d", out, exp);
      end
    end
    last_out = exp;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== exp) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d out_valid=%b out=%0d, want 1/%0d", i, out_valid, out, exp);
      end
    end
    out_ready = 1'b1; start = start_on_hs;
    step();
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake: out_valid=%b busy=%b, want 0/0", out_valid, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || out !== exp) begin
      errors++;
      $display("FAIL idle_after_handshake: busy=%b out=%0d, want 0/%0d", busy, out, exp);
    end
  endtask

  task automatic test_alternating();
    run_window(16'hAAAA, 1'b0, 1'b0);
    get_result(0, 1'b0);
  endtask

  task automatic test_all_ones();
    run_window(16'hFFFF, 1'b0, 1'b0);
    get_result(0, 1'b0);
  endtask

  task automatic test_all_zeros();
    run_window(16'h0000, 1'b0, 1'b0);
    get_result(0, 1'b0);
  endtask

  task automatic test_gaps_and_start_pulses();
    run_window(16'hFFFF, 1'b1, 1'b1);
    get_result(0, 1'b0);
  endtask

  task automatic test_hold_and_handshake_start();
    run_window(16'h1234, 1'b0, 1'b0);
    get_result(10, 1'b1);
  endtask

  task automatic test_reset_mid_window();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in = 1'b1;
      step();
    end
    #2 rst = 1'b0;
    #1;
    last_out = '0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b out_valid=%b out=%0d, want 0/0/0", busy, out_valid, out);
    end
    in_valid = 1'b0; in = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_window(16'h5F3C, 1'b0, 1'b0);
    get_result(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_window(16'h0007, 1'b0, 1'b0);
    get_result(0, 1'b0);
    run_window(16'hFFF0, 1'b0, 1'b0);
    get_result(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_all_ones();
    test_all_zeros();
    test_gaps_and_start_pulses();
    test_hold_and_handshake_start();
    test_reset_mid_window();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d results never produced, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
